if_icache_pref: RTL and testbench
=================================

IF_ICACHE_PREF -- requirements
Module: if_icache_pref

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fetch-address width in bits.
REQ-002 SHALL have parameter INDEX_BITS, default 6, set-index width (2^INDEX_BITS sets).
REQ-003 SHALL have parameter WAYS, default 2, associativity; legal values 1 and 2 only.
REQ-004 SHALL have parameter PREFETCH, default 1, non-zero enables next-line prefetch.
REQ-005 SHALL have ports: clk  in  1  clock, all state updates on rising edge.
REQ-006 SHALL have: rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have: pc  in  ADDR_W  fetch address; pc[1:0] ignored.
REQ-008 SHALL have: flush  in  1  fence.i pulse, invalidates all lines.
REQ-009 SHALL have: pc_o  out  ADDR_W  address of delivered instruction, 0 when stalled.
REQ-010 SHALL have: inst_o  out  32  delivered instruction, 0 when stalled.
REQ-011 SHALL have: if_stall  out  1  high when no instruction is delivered this cycle.
REQ-012 SHALL have: mem_req  out  1  memory fetch request, held until accepted.
REQ-013 SHALL have: mem_addr  out  ADDR_W  word-aligned request address, stable while mem_req high.
REQ-014 SHALL have: mem_ok  in  1  one-cycle response strobe.
REQ-015 SHALL have: mem_pc  in  ADDR_W  address of returned word.
REQ-016 SHALL have: mem_inst  in  32  returned word.

Function
REQ-017 SHALL split word address into tag = pc[ADDR_W-1:INDEX_BITS+2], index = pc[INDEX_BITS+1:2]; each way holds valid bit, tag, 32-bit data; one LRU bit per set when WAYS=2.
REQ-018 SHALL deliver hit combinationally: valid and tag match in any way -> if_stall=0, inst_o=data, pc_o=pc, zero-cycle latency.
REQ-019 SHALL, on miss with mem_ok=1 and mem_pc==pc, bypass: if_stall=0, inst_o=mem_inst, pc_o=pc same cycle.
REQ-020 SHALL otherwise assert if_stall=1, inst_o=0, pc_o=0.
REQ-021 SHALL implement FSM IDLE, MISS, PREF; at most one request outstanding.
REQ-022 IDLE: pc misses (and no bypass) -> MISS, mem_req=1, mem_addr={pc[ADDR_W-1:2],2'b00}, latched.
REQ-023 IDLE: PREFETCH!=0, pc hits or bypasses, pc+4 misses, flush=0 -> PREF, mem_addr=pc+4 latched.
REQ-024 MISS/PREF: mem_req stays 1 with latched mem_addr until mem_ok; on mem_ok -> IDLE.
REQ-025 SHALL fill on every mem_ok at index/tag of mem_pc: matching way if present, else invalid way (way 0 first), else LRU way; LRU updated to point away from filled way.
REQ-026 SHALL update LRU on every hit to point away from hit way; WAYS=1 has no LRU.
REQ-027 pc changing while in PREF or MISS SHALL NOT cancel the request; new pc miss is handled from IDLE after completion.
REQ-028 pc+4 SHALL wrap modulo 2^ADDR_W; prefetch of address 0 after 0xFFFF_FFFC is legal.
REQ-029 flush SHALL clear all valid bits and LRU bits at next edge; a fill arriving same cycle SHALL be discarded; outstanding request completes but data is not stored; if_stall SHALL be 1 during flush cycle.
REQ-030 Simultaneous hit and fill to same set SHALL apply fill first, then LRU from the hit.

Reset
REQ-031 rst_n=0 at edge SHALL clear valid bits, LRU bits, FSM to IDLE, latched address to 0.
REQ-032 While rst_n=0: if_stall=0, inst_o=0, pc_o=0, mem_req=0, mem_addr=0; mem_ok ignored.
REQ-033 Reset mid-request SHALL abandon it; a late mem_ok after reset SHALL fill normally only if rst_n=1.

Structure
REQ-034 Shared package (defines) SHALL hold ZeroWord, True/False, state encodings, default parameter values.
REQ-035 One sub-module if_icache_way (valid/tag/data array, read port plus fill port) instantiated WAYS times.

Verification
REQ-036 Cold miss: pc=0x100, mem_ok after 3 cycles with mem_inst=0x00000013 -> stall 3 cycles, bypass delivers 0x13, next cycle pc=0x100 hits.
REQ-037 Prefetch: pc=0x100 hit, 0x104 absent -> mem_req with mem_addr=0x104; after fill, pc=0x104 hits with zero stall.
REQ-038 Conflict WAYS=2, INDEX_BITS=6: fill 0x000, 0x100, access 0x000, fill 0x200 -> 0x100 evicted, 0x000 and 0x200 hit.
REQ-039 Flush: warm lines, pulse flush -> next access to 0x100 misses and issues mem_req.
REQ-040 Reset mid-miss: mem_req high, rst_n=0 one cycle -> mem_req=0, FSM IDLE, all lines miss.
REQ-041 Redirect during PREF: pc jumps to 0x400 while prefetch 0x104 pending -> mem_addr stays 0x104 until mem_ok, then 0x400 requested.

Source files
------------

// File: rtl/if_icache_pref_pkg.sv
// Shared constants, state encoding and default parameters for the fetch-side
// instruction cache with next-line prefetch.
package if_icache_pref_pkg;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;
   localparam logic        True     = 1'b1;
   localparam logic        False    = 1'b0;

   localparam int DefAddrW     = 32;
   localparam int DefIndexBits = 6;
   localparam int DefWays      = 2;
   localparam int DefPrefetch  = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MISS = 2'd1,
      ST_PREF = 2'd2
   } state_t;

endpackage

// File: rtl/if_icache_way.sv
// One cache way: valid/tag/data arrays with a fetch read port, a next-line
// probe port and a fill port that also reports the valid/match state of its set.
module if_icache_way
   import if_icache_pref_pkg::*;
#(
   parameter int ADDR_W     = DefAddrW,
   parameter int INDEX_BITS = DefIndexBits
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic [INDEX_BITS-1:0]        rd_index,
   input  logic [ADDR_W-INDEX_BITS-3:0] rd_tag,
   output logic                         rd_hit,
   output logic [31:0]                  rd_data,
   input  logic [INDEX_BITS-1:0]        pf_index,
   input  logic [ADDR_W-INDEX_BITS-3:0] pf_tag,
   output logic                         pf_hit,
   input  logic [INDEX_BITS-1:0]        fill_index,
   input  logic [ADDR_W-INDEX_BITS-3:0] fill_tag,
   output logic                         fill_valid,
   output logic                         fill_match,
   input  logic                         fill_we,
   input  logic [31:0]                  fill_data
);

   localparam int SETS  = 1 << INDEX_BITS;
   localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tags [SETS];
   logic [31:0]      data [SETS];

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         valid <= '0;
      end else if (fill_we) begin
         valid[fill_index] <= True;
      end
   end

   // Tag/data need no reset: they are only observed through valid.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tags[fill_index] <= fill_tag;
         data[fill_index] <= fill_data;
      end
   end

   assign rd_hit     = valid[rd_index] && (tags[rd_index] == rd_tag);
   assign rd_data    = data[rd_index];
   assign pf_hit     = valid[pf_index] && (tags[pf_index] == pf_tag);
   assign fill_valid = valid[fill_index];
   assign fill_match = valid[fill_index] && (tags[fill_index] == fill_tag);

endmodule

// File: rtl/if_icache_pref.sv
// Instruction-fetch cache (1 or 2 ways) with zero-latency hit, response bypass
// and single-outstanding next-line prefetch.
//
// state | meaning
// IDLE  | no request outstanding; hit/bypass/miss decided from pc
// MISS  | demand fetch of latched address outstanding
// PREF  | next-line prefetch of latched address outstanding
module if_icache_pref
   import if_icache_pref_pkg::*;
#(
   parameter int ADDR_W     = DefAddrW,
   parameter int INDEX_BITS = DefIndexBits,
   parameter int WAYS       = DefWays,
   parameter int PREFETCH   = DefPrefetch
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc,
   input  logic              flush,
   output logic [ADDR_W-1:0] pc_o,
   output logic [31:0]       inst_o,
   output logic              if_stall,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ok,
   input  logic [ADDR_W-1:0] mem_pc,
   input  logic [31:0]       mem_inst
);

   localparam int SETS = 1 << INDEX_BITS;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] lat_addr, addr_nx;
   logic              discard;
   logic [SETS-1:0]   lru;

   logic [ADDR_W-3:0]     pc_nw;
   logic [WAYS-1:0]       hit_a, hit_b, f_valid, f_match;
   logic [31:0]           data_a [WAYS];
   logic [INDEX_BITS-1:0] pc_index, f_index;
   logic                  hit, hit_way, pf_hit, bypass, fill_en, fill_way, deliver;
   logic [31:0]           data_hit;
   logic                  unused_mem_lo;

   assign unused_mem_lo = ^mem_pc[1:0];

   assign pc_nw    = pc[ADDR_W-1:2] + (ADDR_W-2)'(1);
   assign pc_index = pc[INDEX_BITS+1:2];
   assign f_index  = mem_pc[INDEX_BITS+1:2];

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      if_icache_way #(.ADDR_W(ADDR_W), .INDEX_BITS(INDEX_BITS)) u_way (
         .clk        (clk),
         .rst_n      (rst_n),
         .clr        (flush),
         .rd_index   (pc_index),
         .rd_tag     (pc[ADDR_W-1:INDEX_BITS+2]),
         .rd_hit     (hit_a[g]),
         .rd_data    (data_a[g]),
         .pf_index   (pc_nw[INDEX_BITS-1:0]),
         .pf_tag     (pc_nw[ADDR_W-3:INDEX_BITS]),
         .pf_hit     (hit_b[g]),
         .fill_index (f_index),
         .fill_tag   (mem_pc[ADDR_W-1:INDEX_BITS+2]),
         .fill_valid (f_valid[g]),
         .fill_match (f_match[g]),
         .fill_we    (fill_en && (fill_way == 1'(g))),
         .fill_data  (mem_inst)
      );
   end

   assign hit      = |hit_a;
   assign hit_way  = (WAYS == 2) && hit_a[WAYS-1];
   assign data_hit = hit_way ? data_a[WAYS-1] : data_a[0];
   assign pf_hit   = |hit_b;
   assign bypass   = !hit && mem_ok && (mem_pc[ADDR_W-1:2] == pc[ADDR_W-1:2]);
   assign fill_en  = rst_n && mem_ok && !flush && !discard;

   // Refill an existing copy first, then an empty way, else the LRU victim.
   always_comb begin
      fill_way = 1'b0;
      if (WAYS == 2) begin
         if (|f_match)                fill_way = f_match[WAYS-1];
         else if (!f_valid[0])        fill_way = 1'b0;
         else if (!f_valid[WAYS-1])   fill_way = 1'b1;
         else                         fill_way = lru[f_index];
      end
   end

   always_comb begin
      state_nx = state;
      addr_nx  = lat_addr;
      case (state)
         ST_IDLE: begin
            if (!hit && !bypass) begin
               state_nx = ST_MISS;
               addr_nx  = {pc[ADDR_W-1:2], 2'b00};
            end else if ((PREFETCH != 0) && !pf_hit && !flush) begin
               state_nx = ST_PREF;
               addr_nx  = {pc_nw, 2'b00};
            end
         end
         ST_MISS, ST_PREF: begin
            if (mem_ok) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         lat_addr <= '0;
         discard  <= False;
      end else begin
         state    <= state_nx;
         lat_addr <= addr_nx;
         // A flush while a request is in flight poisons its eventual fill.
         if (mem_ok)                                 discard <= False;
         else if (flush && (state != ST_IDLE))       discard <= True;
      end
   end

   // Later assignment wins, so a hit in the same set overrides the fill's LRU.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         lru <= '0;
      end else if (WAYS == 2) begin
         if (fill_en) lru[f_index]  <= ~fill_way;
         if (hit)     lru[pc_index] <= ~hit_way;
      end
   end

   assign deliver  = rst_n && !flush && (hit || bypass);
   assign if_stall = rst_n && !deliver;
   assign inst_o   = deliver ? (hit ? data_hit : mem_inst) : ZeroWord;
   assign pc_o     = deliver ? pc : '0;
   assign mem_req  = rst_n && (state != ST_IDLE);
   assign mem_addr = rst_n ? lat_addr : '0;

endmodule

// File: tb/tb_if_icache_pref.sv
// Directed self-checking bench for if_icache_pref (default 2-way, 64 sets, prefetch on).
module tb_if_icache_pref;

   logic        clk = 1'b0;
   logic        rst_n, flush, mem_ok;
   logic [31:0] pc, mem_pc, mem_inst;
   logic [31:0] pc_o, inst_o, mem_addr;
   logic        if_stall, mem_req;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic        stall;
      logic [31:0] inst;
      logic [31:0] pco;
   } vec_t;
   vec_t tbl [6];

   if_icache_pref dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pc       (pc),
      .flush    (flush),
      .pc_o     (pc_o),
      .inst_o   (inst_o),
      .if_stall (if_stall),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_ok   (mem_ok),
      .mem_pc   (mem_pc),
      .mem_inst (mem_inst)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] dat(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h1357_9bdf);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Serve outstanding requests until address a is delivered (via hit or bypass).
   task automatic fetch(input logic [31:0] a);
      bit done = 0;
      pc = a;
      mem_ok = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (!if_stall) begin
            chk($sformatf("fetch_%h", a), inst_o, dat(a));
            done = 1;
         end else if (mem_req) begin
            mem_ok = 1'b1; mem_pc = mem_addr; mem_inst = dat(mem_addr);
            #1;
            if (!if_stall) begin
               chk($sformatf("fetch_%h", a), inst_o, dat(a));
               done = 1;
            end
         end
         tick();
         mem_ok = 1'b0;
      end
      if (!done) chk($sformatf("fetch_timeout_%h", a), 32'd0, 32'd1);
   endtask

   // Answer requests with pc held until the bus stays quiet for two cycles.
   task automatic drain();
      int quiet = 0;
      for (int i = 0; i < 20 && quiet < 2; i++) begin
         #1;
         if (mem_req) begin
            mem_ok = 1'b1; mem_pc = mem_addr; mem_inst = dat(mem_addr);
            quiet = 0;
         end else begin
            quiet++;
         end
         tick();
         mem_ok = 1'b0;
      end
      if (quiet < 2) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Set 0 after the conflict sequence holds 0x000 and 0x200; set 1 holds 0x004.
      tbl[0] = '{32'h000, 1'b0, dat(32'h000), 32'h000};
      tbl[1] = '{32'h200, 1'b0, dat(32'h200), 32'h200};
      tbl[2] = '{32'h100, 1'b1, 32'h0,        32'h0};
      tbl[3] = '{32'h004, 1'b0, dat(32'h004), 32'h004};
      tbl[4] = '{32'h300, 1'b1, 32'h0,        32'h0};
      tbl[5] = '{32'h104, 1'b1, 32'h0,        32'h0};

      rst_n = 1'b0; flush = 1'b0; pc = 32'h100;
      mem_ok = 1'b1; mem_pc = 32'h100; mem_inst = 32'hdead_beef;
      #2;
      chk("rst_stall", if_stall, 0);
      chk("rst_inst", inst_o, 0);
      chk("rst_pc_o", pc_o, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      tick();
      tick();

      // Cold miss: three stall cycles, then bypass of the returned word.
      rst_n = 1'b1; mem_ok = 1'b0; pc = 32'h100;
      #1;
      chk("cold_c0_stall", if_stall, 1);
      chk("cold_c0_inst", inst_o, 0);
      chk("cold_c0_pc_o", pc_o, 0);
      chk("cold_c0_req", mem_req, 0);
      tick();
      chk("cold_c1_req", mem_req, 1);
      chk("cold_c1_addr", mem_addr, 32'h100);
      chk("cold_c1_stall", if_stall, 1);
      tick();
      chk("cold_c2_stall", if_stall, 1);
      tick();
      mem_ok = 1'b1; mem_pc = 32'h100; mem_inst = 32'h13;
      #1;
      chk("bypass_stall", if_stall, 0);
      chk("bypass_inst", inst_o, 32'h13);
      chk("bypass_pc_o", pc_o, 32'h100);
      tick();
      mem_ok = 1'b0;
      #1;
      chk("hit_100_stall", if_stall, 0);
      chk("hit_100_inst", inst_o, 32'h13);
      tick();

      // Prefetch of 0x104 issued; redirect to 0x400 must not cancel it.
      chk("pref_req", mem_req, 1);
      chk("pref_addr", mem_addr, 32'h104);
      pc = 32'h400;
      #1;
      chk("redir_stall", if_stall, 1);
      tick();
      chk("redir_addr_hold1", mem_addr, 32'h104);
      tick();
      chk("redir_addr_hold2", mem_addr, 32'h104);
      chk("redir_req_hold", mem_req, 1);
      mem_ok = 1'b1; mem_pc = 32'h104; mem_inst = dat(32'h104);
      #1;
      chk("pref_resp_no_bypass", if_stall, 1);
      tick();
      mem_ok = 1'b0;
      #1;
      chk("redir_idle_req", mem_req, 0);
      tick();
      chk("redir_miss_req", mem_req, 1);
      chk("redir_miss_addr", mem_addr, 32'h400);
      mem_ok = 1'b1; mem_pc = 32'h400; mem_inst = dat(32'h400);
      #1;
      chk("redir_bypass_inst", inst_o, dat(32'h400));
      tick();
      mem_ok = 1'b0; pc = 32'h104;
      #1;
      chk("pref_hit_stall", if_stall, 0);
      chk("pref_hit_inst", inst_o, dat(32'h104));
      chk("pref_hit_pc_o", pc_o, 32'h104);

      // Flush: warm line is lost, next access re-requests it.
      drain();
      pc = 32'h100;
      #1;
      chk("warm_100", inst_o, 32'h13);
      flush = 1'b1;
      #1;
      chk("flush_stall", if_stall, 1);
      tick();
      flush = 1'b0;
      #1;
      chk("post_flush_miss", if_stall, 1);
      tick();
      chk("post_flush_req", mem_req, 1);
      chk("post_flush_addr", mem_addr, 32'h100);
      flush = 1'b1;
      tick();
      flush = 1'b0; mem_ok = 1'b1; mem_pc = 32'h100; mem_inst = 32'h13;
      tick();
      mem_ok = 1'b0;
      #1;
      chk("discarded_fill", if_stall, 1);
      fetch(32'h100);

      // Conflict in set 0: 0x100 is LRU once 0x000 has been touched.
      fetch(32'h000);
      pc = 32'h000;
      #1;
      chk("access_000", if_stall, 0);
      tick();
      fetch(32'h200);
      for (int i = 0; i < 6; i++) begin
         pc = tbl[i].pc;
         #1;
         chk($sformatf("tbl%0d_stall", i), if_stall, tbl[i].stall);
         chk($sformatf("tbl%0d_inst", i), inst_o, tbl[i].inst);
         chk($sformatf("tbl%0d_pc_o", i), pc_o, tbl[i].pco);
         tick();
      end

      // Reset while a request is outstanding.
      chk("pre_reset_req", mem_req, 1);
      rst_n = 1'b0;
      #1;
      chk("in_reset_req", mem_req, 0);
      chk("in_reset_addr", mem_addr, 0);
      chk("in_reset_stall", if_stall, 0);
      tick();
      rst_n = 1'b1; pc = 32'h000;
      #1;
      chk("post_rst_miss_000", if_stall, 1);
      chk("post_rst_req", mem_req, 0);
      pc = 32'h200;
      #1;
      chk("post_rst_miss_200", if_stall, 1);
      pc = 32'h000; mem_ok = 1'b1; mem_pc = 32'h204; mem_inst = dat(32'h204);
      tick();
      mem_ok = 1'b0; pc = 32'h204;
      #1;
      chk("late_fill_hit", inst_o, dat(32'h204));
      chk("late_fill_req", mem_req, 1);
      chk("late_fill_addr", mem_addr, 32'h000);

      // Next-line prefetch wraps past the top of the address space.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      fetch(32'hffff_fffc);
      #1;
      chk("wrap_hit", if_stall, 0);
      tick();
      chk("wrap_req", mem_req, 1);
      chk("wrap_addr", mem_addr, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
